// File: rtl/md_issue.sv
// Issue/stall control between the E stage and a multi-cycle multiply/divide unit.
// Tracks the unit through IDLE/PEND/BUSY, handles mfhi/mflo/mthi/mtlo, and guards with a watchdog.
module md_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic        op_lo,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        cancel,
  input  logic        md_busy,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  output logic [3:0]  md_op,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        mt_hi,
  output logic        mt_lo,
  output logic [31:0] mt_data,
  output logic        stall,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        wd_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PEND = 2'd1;
  localparam logic [1:0] BUSY = 2'd2;

  logic [1:0] state;
  logic [3:0] wd;
  logic       live;
  logic       idle;
  logic       is_mf;

  assign live  = op_valid && (op_code != 3'd0) && !cancel;
  assign idle  = (state == IDLE);
  assign is_mf = (op_code == 3'd5) || (op_code == 3'd6);

  // Any live op stalls while the unit is in flight; it retries from held inputs.
  always_comb begin
    md_op   = '0;
    md_a    = '0;
    md_b    = '0;
    mt_hi   = 1'b0;
    mt_lo   = 1'b0;
    mt_data = '0;
    stall   = live && !idle;
    if (live && idle) begin
      case (op_code)
        3'd1: md_op = 4'b1000;
        3'd2: md_op = 4'b0100;
        3'd3: md_op = 4'b0010;
        3'd4: md_op = 4'b0001;
        3'd7: begin
          mt_hi   = !op_lo;
          mt_lo   = op_lo;
          mt_data = rs_val;
        end
        default: ;
      endcase
      if (md_op != '0) begin
        md_a = rs_val;
        md_b = rt_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wd       <= '0;
      wd_err   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= live && idle && is_mf;
      if (live && idle && is_mf)
        rd_data <= (op_code == 3'd5) ? md_hi : md_lo;
      case (state)
        IDLE: begin
          wd <= '0;
          if (md_op != '0)
            state <= PEND;
        end
        PEND: begin
          wd    <= '0;
          state <= BUSY;
        end
        BUSY: begin
          wd <= wd + 4'd1;
          if (!md_busy) begin
            state <= IDLE;
          end else if (wd == 4'd14) begin
            // Counter reaches 15 on this edge with the unit still busy.
            wd_err <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_issue.sv
// Scoreboard bench for md_issue: stimulus pushes expected unit commands, strobes and reads;
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_md_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op_code;
  logic        op_lo;
  logic [31:0] rs_val, rt_val;
  logic        cancel;
  logic        md_busy;
  logic [31:0] md_hi, md_lo;
  logic [3:0]  md_op;
  logic [31:0] md_a, md_b;
  logic        mt_hi, mt_lo;
  logic [31:0] mt_data;
  logic        stall, rd_valid, wd_err;
  logic [31:0] rd_data;

  always #5 clk = ~clk;

  md_issue dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code), .op_lo(op_lo),
    .rs_val(rs_val), .rt_val(rt_val), .cancel(cancel), .md_busy(md_busy),
    .md_hi(md_hi), .md_lo(md_lo), .md_op(md_op), .md_a(md_a), .md_b(md_b),
    .mt_hi(mt_hi), .mt_lo(mt_lo), .mt_data(mt_data), .stall(stall),
    .rd_valid(rd_valid), .rd_data(rd_data), .wd_err(wd_err)
  );

  localparam int unsigned K_MD = 0, K_MTHI = 1, K_MTLO = 2, K_RD = 3;

  typedef struct {
    int unsigned kind;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic push(input int unsigned kind, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    exp_t e;
    e.kind = kind; e.op = op; e.a = a; e.b = b;
    q.push_back(e);
  endtask

  task automatic pop_check(input int unsigned kind, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
    exp_t e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_output: kind %0d data %h with empty queue", kind, a);
    end else begin
      e = q.pop_front();
      check("out_kind", kind, e.kind);
      check("out_op", {28'd0, op}, {28'd0, e.op});
      check("out_a", a, e.a);
      check("out_b", b, e.b);
    end
  endtask

  // Multiply/divide unit model: fixed busy span, result written when busy falls.
  logic        hang = 1'b0;
  int unsigned cnt;
  logic [31:0] p_hi, p_lo;

  always @(posedge clk) begin
    if (reset) begin
      md_busy <= 1'b0;
      md_hi   <= '0;
      md_lo   <= '0;
      cnt     <= 0;
    end else begin
      if (mt_hi) md_hi <= mt_data;
      if (mt_lo) md_lo <= mt_data;
      if (md_op != 4'b0000) begin
        md_busy <= 1'b1;
        cnt     <= hang ? 0 : ((md_op[3] || md_op[2]) ? 5 : 10);
        case (md_op)
          4'b1000: {p_hi, p_lo} <= $signed(md_a) * $signed(md_b);
          4'b0100: {p_hi, p_lo} <= {32'd0, md_a} * {32'd0, md_b};
          4'b0010: begin
            p_lo <= $signed(md_a) / $signed(md_b);
            p_hi <= $signed(md_a) % $signed(md_b);
          end
          default: begin
            p_lo <= md_a / md_b;
            p_hi <= md_a % md_b;
          end
        endcase
      end else if (cnt == 1) begin
        md_busy <= 1'b0;
        md_hi   <= p_hi;
        md_lo   <= p_lo;
        cnt     <= 0;
      end else if (cnt > 1) begin
        cnt <= cnt - 1;
      end else if (!hang) begin
        md_busy <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (rd_valid) pop_check(K_RD, 4'd0, rd_data, 32'd0);
      if (md_op != 4'b0000) pop_check(K_MD, md_op, md_a, md_b);
      if (mt_hi) pop_check(K_MTHI, 4'd0, mt_data, 32'd0);
      if (mt_lo) pop_check(K_MTLO, 4'd0, mt_data, 32'd0);
      if (md_op != 4'b0000 || mt_hi || mt_lo)
        check("onehot", $countones({md_op, mt_hi, mt_lo}), 32'd1);
    end
  end

  task automatic clear_op();
    op_valid = 1'b0; op_code = 3'd0; op_lo = 1'b0; cancel = 1'b0;
    rs_val = '0; rt_val = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Hold an op until it stops stalling; returns the number of stalled cycles.
  task automatic issue(input logic [2:0] code, input logic lo, input logic [31:0] a,
                       input logic [31:0] b, output int stalls);
    op_valid = 1'b1; op_code = code; op_lo = lo; rs_val = a; rt_val = b; cancel = 1'b0;
    stalls = 0;
    @(negedge clk);
    while (stall && stalls < 40) begin
      stalls++;
      @(negedge clk);
    end
    if (stall) check("stall_timeout", {31'd0, stall}, 32'd0);
    next_cycle();
    clear_op();
  endtask

  int s;

  initial begin
    reset = 1'b1;
    clear_op();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_wd_err", {31'd0, wd_err}, 32'd0);
    check("rst_md_op", {28'd0, md_op}, 32'd0);
    next_cycle();
    reset = 1'b0;
    next_cycle();

    // mult 7 * -3, then mflo stalls until the unit finishes
    push(K_MD, 4'b1000, 32'd7, 32'hFFFF_FFFD);
    issue(3'd1, 1'b0, 32'd7, 32'hFFFF_FFFD, s);
    check("mult_issue_stall", s, 32'd0);
    push(K_RD, 4'd0, 32'hFFFF_FFEB, 32'd0);
    issue(3'd6, 1'b0, 32'd0, 32'd0, s);
    check("mflo_stall_cycles", s, 32'd6);
    repeat (2) next_cycle();

    // divu 100 / 7, mfhi = 2 and mflo = 14
    push(K_MD, 4'b0001, 32'd100, 32'd7);
    issue(3'd4, 1'b0, 32'd100, 32'd7, s);
    check("divu_issue_stall", s, 32'd0);
    push(K_RD, 4'd0, 32'd2, 32'd0);
    issue(3'd5, 1'b0, 32'd0, 32'd0, s);
    check("mfhi_stall_cycles", s, 32'd11);
    push(K_RD, 4'd0, 32'd14, 32'd0);
    issue(3'd6, 1'b0, 32'd0, 32'd0, s);
    check("mflo_after_div_stall", s, 32'd0);
    repeat (2) next_cycle();

    // cancelled div and an invalid op produce nothing; block stays idle
    op_valid = 1'b1; op_code = 3'd3; rs_val = 32'd9; rt_val = 32'd3; cancel = 1'b1;
    @(negedge clk);
    check("cancel_md_op", {28'd0, md_op}, 32'd0);
    check("cancel_stall", {31'd0, stall}, 32'd0);
    next_cycle();
    op_valid = 1'b0; op_code = 3'd1; cancel = 1'b0;
    @(negedge clk);
    check("invalid_md_op", {28'd0, md_op}, 32'd0);
    next_cycle();
    push(K_MTLO, 4'd0, 32'h0000_A5A5, 32'd0);
    issue(3'd7, 1'b1, 32'h0000_A5A5, 32'd0, s);
    check("after_cancel_idle", s, 32'd0);

    // mthi in idle, then mthi behind a busy mult issues exactly once when it ends
    push(K_MTHI, 4'd0, 32'hDEAD_BEEF, 32'd0);
    issue(3'd7, 1'b0, 32'hDEAD_BEEF, 32'd0, s);
    check("mthi_idle_stall", s, 32'd0);
    push(K_MD, 4'b1000, 32'd3, 32'd4);
    issue(3'd1, 1'b0, 32'd3, 32'd4, s);
    next_cycle();
    push(K_MTHI, 4'd0, 32'h1234_5678, 32'd0);
    issue(3'd7, 1'b0, 32'h1234_5678, 32'd0, s);
    check("mthi_busy_stall", s, 32'd5);
    push(K_RD, 4'd0, 32'h1234_5678, 32'd0);
    issue(3'd5, 1'b0, 32'd0, 32'd0, s);
    push(K_RD, 4'd0, 32'd12, 32'd0);
    issue(3'd6, 1'b0, 32'd0, 32'd0, s);
    repeat (2) next_cycle();

    // unit never drops busy: watchdog fires after 15 BUSY cycles
    check("wd_err_before", {31'd0, wd_err}, 32'd0);
    hang = 1'b1;
    push(K_MD, 4'b0100, 32'd1, 32'd1);
    issue(3'd2, 1'b0, 32'd1, 32'd1, s);
    push(K_RD, 4'd0, 32'h1234_5678, 32'd0);
    issue(3'd5, 1'b0, 32'd0, 32'd0, s);
    check("wd_stall_cycles", s, 32'd16);
    @(negedge clk);
    check("wd_err_set", {31'd0, wd_err}, 32'd1);
    hang = 1'b0;
    repeat (2) next_cycle();
    check("wd_err_sticky", {31'd0, wd_err}, 32'd1);

    // reset while BUSY returns to IDLE at once
    push(K_MD, 4'b1000, 32'd2, 32'd2);
    issue(3'd1, 1'b0, 32'd2, 32'd2, s);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    push(K_MTLO, 4'd0, 32'h0BAD_F00D, 32'd0);
    op_valid = 1'b1; op_code = 3'd7; op_lo = 1'b1; rs_val = 32'h0BAD_F00D;
    @(negedge clk);
    check("post_rst_stall", {31'd0, stall}, 32'd0);
    check("post_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("post_rst_wd_err", {31'd0, wd_err}, 32'd0);
    next_cycle();
    clear_op();
    repeat (3) next_cycle();

    check("queue_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/md_issue.md
MD_ISSUE -- requirements
Module: md_issue

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the ports are named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op_valid  input  1  E-stage instruction valid.
REQ-005 op_code  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi/mtlo, with op_code 7 qualified by op_lo.
REQ-006 op_lo  input  1  with op_code 7: 1 = mtlo, 0 = mthi.
REQ-007 rs_val, rt_val  input  32 each  forwarded operands.
REQ-008 cancel  input  1  exception or eret in M; kills the current E-stage op.
REQ-009 md_busy  input  1  busy flag from the multiply/divide unit.
REQ-010 md_hi, md_lo  input  32 each  HI/LO from the unit.
REQ-011 md_op  output  4  one-hot {mult,multu,div,divu} command to the unit, held for one cycle.
REQ-012 md_a, md_b  output  32 each  operands to the unit.
REQ-013 mt_hi, mt_lo  output  1 each  one-cycle write strobes to the unit.
REQ-014 mt_data  output  32  data for the mthi/mtlo write.
REQ-015 stall  output  1  freeze the E stage and everything upstream.
REQ-016 rd_valid  output  1  one-cycle pulse; rd_data holds an mfhi/mflo result.
REQ-017 rd_data  output  32  registered HI or LO value.
REQ-018 wd_err  output  1  sticky watchdog error.

Function
REQ-019 FSM states SHALL be IDLE, PEND and BUSY, and the state SHALL be registered.
REQ-020 An op is "live" when op_valid=1, op_code!=0 and cancel=0; a non-live op SHALL produce no strobe, no stall and no state change.
REQ-021 In IDLE, a live mult/multu/div/divu SHALL assert the matching md_op bit for that cycle only, drive md_a=rs_val and md_b=rt_val, leave stall=0 and go to PEND.
REQ-022 PEND SHALL last exactly one cycle and then go to BUSY; stall=1 in PEND for any live op.
REQ-023 BUSY SHALL return to IDLE on the first cycle md_busy=0; stall=1 in BUSY for any live op.
REQ-024 The mult family SHALL be operation latency: result visible 6 cycles after issue for mult/multu and 11 cycles after issue for div/divu; the block relies only on md_busy, not on fixed counts.
REQ-025 In IDLE, a live mfhi/mflo SHALL leave stall=0 and, at the next edge, register md_hi/md_lo into rd_data with rd_valid=1 for one cycle.
REQ-026 In IDLE, a live mthi/mtlo SHALL pulse mt_hi or mt_lo combinationally for that cycle with mt_data=rs_val.
REQ-027 While stalled, md_op, mt_hi, mt_lo and the rd_valid capture SHALL all be 0; the stalled op SHALL be re-evaluated each cycle from the held inputs.
REQ-028 md_op, mt_hi and mt_lo SHALL be mutually exclusive and at most one-hot in any cycle.
REQ-029 cancel SHALL never abort an op already in PEND/BUSY, and the FSM SHALL keep tracking md_busy.
REQ-030 A 4-bit watchdog SHALL count BUSY cycles; if it reaches 15 with md_busy=1, wd_err SHALL be set and the FSM forced to IDLE; wd_err clears only on reset.
REQ-031 md_a and md_b SHALL be 0 whenever md_op=0.

Reset
REQ-032 On reset the FSM SHALL be IDLE, the watchdog 0 and wd_err 0.
REQ-033 On reset rd_valid SHALL be 0, rd_data 0 and stall 0.
REQ-034 A reset asserted in PEND or BUSY SHALL return the FSM to IDLE at that edge regardless of md_busy.

Verification
REQ-035 mult 7 by -3 in IDLE, unit model busy for 5 cycles -> md_op=1000 for one cycle; a following mflo stalls until md_busy falls, then rd_data=0xFFFFFFEB with rd_valid pulsing once.
REQ-036 divu 100 by 7 followed by mfhi -> 11 cycles of stall at most; rd_data=2.
REQ-037 div issued with cancel=1 -> md_op=0, stall=0, FSM stays IDLE.
REQ-038 mthi 0xDEADBEEF in IDLE -> mt_hi=1 with mt_data=0xDEADBEEF; the same op during BUSY stalls, and the strobe appears only once, after BUSY ends.
REQ-039 Unit model holds md_busy=1 forever -> wd_err=1 after 15 BUSY cycles and the FSM returns to IDLE.
REQ-040 Reset pulsed in BUSY -> next cycle IDLE, stall=0, rd_valid=0.
